// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: in-order req/gnt/rvalid fetch into a small PC-tagged FIFO.
// Optional perf counters (stall cycles, discarded responses) enabled by defining IFB_PERF_CNT_EN.
module ifetch_prefetch_buffer #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_gnt,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   output logic        f_valid,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   input  logic        f_ready
`ifdef IFB_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {BOOT, RUN} state_t;

   state_t           state_reg, state_next;
   logic [31:0]      fetch_pc_reg, resp_pc_reg;
   logic [CW-1:0]    count_reg, outstanding_reg, drop_cnt_reg;
   logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
   logic [63:0]      mem_reg [DEPTH];
   logic             issue, pop, push, drop;
   logic [31:0]      target_pc;

   assign target_pc = flush_pc & ~32'd3;
   assign im_addr   = fetch_pc_reg;
   assign f_pc      = mem_reg[rd_ptr_reg][63:32];
   assign f_instr   = mem_reg[rd_ptr_reg][31:0];

   always_comb begin
      state_next = state_reg;
      im_req     = 1'b0;
      f_valid    = 1'b0;
      if (state_reg == BOOT)
         state_next = RUN;
      // Credit rule: every granted request already owns a FIFO slot.
      if (state_reg == RUN && !flush && outstanding_reg < CW'(MAX_OUTSTANDING) &&
          ({1'b0, count_reg} + {1'b0, outstanding_reg}) < (CW+1)'(DEPTH))
         im_req = 1'b1;
      f_valid = (count_reg != '0) && !flush;
   end

   assign issue = im_req && im_gnt;
   assign pop   = f_valid && f_ready;
   assign drop  = im_rvalid && (flush || drop_cnt_reg != '0);
   assign push  = im_rvalid && !drop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= BOOT;
         fetch_pc_reg    <= RESET_PC;
         resp_pc_reg     <= RESET_PC;
         count_reg       <= '0;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= {RESET_PC, 32'h0};
      end else begin
         state_reg       <= state_next;
         outstanding_reg <= outstanding_reg + CW'(issue) - CW'(im_rvalid);
         if (flush) begin
            // Responses still owed to the old stream must be thrown away.
            fetch_pc_reg <= target_pc;
            resp_pc_reg  <= target_pc;
            drop_cnt_reg <= outstanding_reg - CW'(im_rvalid);
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
         end else begin
            if (issue)
               fetch_pc_reg <= fetch_pc_reg + 32'd4;
            if (drop)
               drop_cnt_reg <= drop_cnt_reg - CW'(1);
            if (push) begin
               mem_reg[wr_ptr_reg] <= {resp_pc_reg, im_rdata};
               wr_ptr_reg          <= wr_ptr_reg + PW'(1);
               resp_pc_reg         <= resp_pc_reg + 32'd4;
            end
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
         end
      end
   end

`ifdef IFB_PERF_CNT_EN
   logic [31:0] stall_cnt_reg, drop_ev_cnt_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg   <= '0;
         drop_ev_cnt_reg <= '0;
      end else begin
         if (state_reg == RUN && f_ready && !f_valid && stall_cnt_reg != '1)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         if (drop && drop_ev_cnt_reg != '1)
            drop_ev_cnt_reg <= drop_ev_cnt_reg + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_reg;
   assign perf_drop_cnt  = drop_ev_cnt_reg;
`endif

`ifndef SYNTHESIS
   a_rvalid_owed : assert property (@(posedge clk) disable iff (!reset)
      im_rvalid |-> outstanding_reg != '0);
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Randomised bench for ifetch_prefetch_buffer against a PC-stream model with an in-order memory.
module tb_ifetch_prefetch_buffer;
   localparam int          DEPTH = 4;
   localparam int          MAXO  = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, im_gnt = 1'b0, im_rvalid = 1'b0, f_ready = 1'b0;
   logic [31:0] flush_pc = '0, im_rdata = '0;
   logic        im_req, f_valid;
   logic [31:0] im_addr, f_instr, f_pc;
`ifdef IFB_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_drop_cnt;
`endif

   ifetch_prefetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
      .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
      .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
      .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc), .f_ready(f_ready)
`ifdef IFB_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] act; logic [31:0] exp; int cyc; } grant_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] exp_pc; logic [31:0] exp_instr; int cyc; } pop_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   grant_t grant_q[$];
   pop_t   pop_q[$];
   mreq_t  mem_q[$];
   int     tests = 0, fails = 0;
   int     cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
   int     tb_outst = 0, max_outst = 0, req_at_max = 0;
   logic   last_req, last_fv;
   logic [31:0] exp_fetch = RPC, exp_pop = RPC;

   // Memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234 ^ (a << 3);
   endfunction

   // One clock: drive inputs, observe, advance model, step past the edge.
   task automatic cycle(input bit rdy, input bit gnt, input bit fl, input logic [31:0] fpc);
      mreq_t m; grant_t g; pop_t p; bit rv;
      rv = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      f_ready = rdy; im_gnt = gnt; flush = fl; flush_pc = fpc; im_rvalid = rv;
      im_rdata = rv ? mem_word(mem_q[0].addr) : $urandom;
      #1;
      last_req = im_req; last_fv = f_valid;
      if (im_req && tb_outst >= MAXO) req_at_max++;
      if (im_req && im_gnt) begin
         g.act = im_addr; g.exp = exp_fetch; g.cyc = cyc; grant_q.push_back(g);
         exp_fetch = exp_fetch + 32'd4;
         m.addr = im_addr; m.due = cyc + int'($urandom_range(lat_max, lat_min));
         if (m.due <= last_due) m.due = last_due + 1;
         last_due = m.due; mem_q.push_back(m); tb_outst++;
      end
      if (f_valid && f_ready) begin
         p.pc = f_pc; p.instr = f_instr; p.exp_pc = exp_pop; p.exp_instr = mem_word(exp_pop); p.cyc = cyc;
         pop_q.push_back(p); exp_pop = exp_pop + 32'd4;
      end
      if (rv) begin void'(mem_q.pop_front()); tb_outst--; end
      if (fl) begin exp_fetch = fpc & ~32'd3; exp_pop = fpc & ~32'd3; end
      if (tb_outst > max_outst) max_outst = tb_outst;
      @(posedge clk); #1; cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b0; flush = 1'b0; im_gnt = 1'b0; im_rvalid = 1'b0; f_ready = 1'b0;
      mem_q.delete(); last_due = cyc; tb_outst = 0;
      exp_fetch = RPC; exp_pop = RPC;
      repeat (2) @(posedge clk);
      #1; reset = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      cycle(1, 0, 0, 0);
      while ((mem_q.size() != 0 || f_valid) && n < 60) begin cycle(1, 0, 0, 0); n++; end
      tests++;
      if (mem_q.size() != 0 || f_valid) begin
         fails++; $display("FAIL drain_timeout: pending=%0d f_valid=%b required 0/0", mem_q.size(), f_valid);
      end
   endtask

   task automatic clear_obs();
      grant_q.delete(); pop_q.delete(); max_outst = tb_outst; req_at_max = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0; #1;
      tests++; if (im_req !== 1'b0 || f_valid !== 1'b0) begin fails++; $display("FAIL reset_outputs: im_req=%b f_valid=%b required 0/0", im_req, f_valid); end
      tests++; if (im_addr !== RPC || f_pc !== RPC) begin fails++; $display("FAIL reset_pcs: im_addr=%h f_pc=%h required %h", im_addr, f_pc, RPC); end
      tests++; if (f_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: f_instr=%h required 0", f_instr); end
      do_reset();
      #1;
      tests++; if (im_req !== 1'b0) begin fails++; $display("FAIL boot_req: im_req=%b required 0", im_req); end
`ifdef IFB_PERF_CNT_EN
      tests++; if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin fails++; $display("FAIL reset_perf: stall=%0d drop=%0d required 0/0", perf_stall_cnt, perf_drop_cnt); end
`endif
      @(posedge clk); #1; cyc++;
      tests++; if (im_req !== 1'b1 || im_addr !== RPC) begin fails++; $display("FAIL run_first_req: im_req=%b im_addr=%h required 1/%h", im_req, im_addr, RPC); end
      $display("[TB] reset: done");
   endtask

   task automatic test_stream();
      clear_obs(); lat_min = 1; lat_max = 1;
      repeat (30) cycle(1, 1, 0, 0);
      drain();
      foreach (grant_q[i]) begin tests++; if (grant_q[i].act !== grant_q[i].exp) begin fails++; $display("FAIL stream_grant[%0d]: im_addr=%h required %h", i, grant_q[i].act, grant_q[i].exp); end end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL stream_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      tests++; if (pop_q.size() != grant_q.size() || pop_q.size() < 25) begin fails++; $display("FAIL stream_count: pops=%0d grants=%0d required equal and >=25", pop_q.size(), grant_q.size()); end
      if (pop_q.size() >= 20) begin
         tests++; if (pop_q[0].cyc != grant_q[0].cyc + 2) begin fails++; $display("FAIL stream_latency: first pop cycle=%0d required %0d", pop_q[0].cyc, grant_q[0].cyc + 2); end
         for (int i = 1; i < 20; i++) begin tests++; if (pop_q[i].cyc != pop_q[i-1].cyc + 1) begin fails++; $display("FAIL stream_rate[%0d]: cycle=%0d required %0d", i, pop_q[i].cyc, pop_q[i-1].cyc + 1); end end
      end
      $display("[TB] stream: %0d grants %0d pops", grant_q.size(), pop_q.size());
   endtask

   task automatic test_full();
      do_reset(); clear_obs(); lat_min = 1; lat_max = 1;
      repeat (12) cycle(0, 1, 0, 0);
      tests++; if (grant_q.size() != DEPTH) begin fails++; $display("FAIL full_grants: grants=%0d required %0d", grant_q.size(), DEPTH); end
      tests++; if (im_req !== 1'b0 || f_valid !== 1'b1) begin fails++; $display("FAIL full_state: im_req=%b f_valid=%b required 0/1", im_req, f_valid); end
      repeat (DEPTH) cycle(1, 0, 0, 0);
      tests++; if (pop_q.size() != DEPTH) begin fails++; $display("FAIL full_pops: pops=%0d required %0d", pop_q.size(), DEPTH); end
      cycle(1, 1, 0, 0);
      tests++; if (grant_q.size() != DEPTH + 1 || grant_q[grant_q.size()-1].act !== 32'h10) begin fails++; $display("FAIL full_resume: grants=%0d last addr=%h required %0d/00000010", grant_q.size(), grant_q[grant_q.size()-1].act, DEPTH + 1); end
      drain();
      foreach (grant_q[i]) begin tests++; if (grant_q[i].act !== grant_q[i].exp) begin fails++; $display("FAIL full_grant[%0d]: im_addr=%h required %h", i, grant_q[i].act, grant_q[i].exp); end end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL full_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] full: %0d grants %0d pops", grant_q.size(), pop_q.size());
   endtask

   task automatic test_latency();
      clear_obs(); lat_min = 3; lat_max = 3;
      repeat (40) cycle(1, 1, 0, 0);
      drain();
      tests++; if (max_outst != MAXO) begin fails++; $display("FAIL latency_max_outstanding: max=%0d required %0d", max_outst, MAXO); end
      tests++; if (req_at_max != 0) begin fails++; $display("FAIL latency_req_at_max: cycles=%0d required 0", req_at_max); end
      tests++; if (pop_q.size() != grant_q.size()) begin fails++; $display("FAIL latency_count: pops=%0d required %0d", pop_q.size(), grant_q.size()); end
      foreach (grant_q[i]) begin tests++; if (grant_q[i].act !== grant_q[i].exp) begin fails++; $display("FAIL latency_grant[%0d]: im_addr=%h required %h", i, grant_q[i].act, grant_q[i].exp); end end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL latency_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] latency: %0d grants max outstanding %0d", grant_q.size(), max_outst);
   endtask

   task automatic test_flush();
      int n;
      clear_obs(); lat_min = 3; lat_max = 3; n = 0;
      while (tb_outst < 2 && n < 10) begin cycle(1, 1, 0, 0); n++; end
      tests++; if (tb_outst != 2) begin fails++; $display("FAIL flush_setup: outstanding=%0d required 2", tb_outst); end
      cycle(1, 1, 1, 32'h0000_1003);
      tests++; if (last_req !== 1'b0 || last_fv !== 1'b0) begin fails++; $display("FAIL flush_cycle: im_req=%b f_valid=%b required 0/0", last_req, last_fv); end
      tests++; if (im_addr !== 32'h0000_1000) begin fails++; $display("FAIL flush_addr: im_addr=%h required 00001000", im_addr); end
      repeat (20) cycle(1, 1, 0, 0);
      drain();
      tests++; if (pop_q.size() == 0 || pop_q[0].pc !== 32'h0000_1000) begin fails++; $display("FAIL flush_first_pc: pops=%0d first pc=%h required 00001000", pop_q.size(), pop_q.size() ? pop_q[0].pc : 32'h0); end
      foreach (grant_q[i]) begin tests++; if (grant_q[i].act !== grant_q[i].exp) begin fails++; $display("FAIL flush_grant[%0d]: im_addr=%h required %h", i, grant_q[i].act, grant_q[i].exp); end end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL flush_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] flush: %0d pops after redirect", pop_q.size());
   endtask

   task automatic test_flush_rvalid();
      clear_obs(); lat_min = 1; lat_max = 1;
      cycle(1, 1, 0, 0);
      cycle(1, 0, 1, 32'h0000_3000);
      flush = 1'b0; im_gnt = 1'b0; im_rvalid = 1'b0; #1;
      tests++; if (f_valid !== 1'b0) begin fails++; $display("FAIL flush_rvalid_empty: f_valid=%b required 0", f_valid); end
      tests++; if (im_addr !== 32'h0000_3000) begin fails++; $display("FAIL flush_rvalid_addr: im_addr=%h required 00003000", im_addr); end
      repeat (10) cycle(1, 1, 0, 0);
      drain();
      tests++; if (pop_q.size() == 0 || pop_q[0].pc !== 32'h0000_3000) begin fails++; $display("FAIL flush_rvalid_first_pc: pops=%0d first pc=%h required 00003000", pop_q.size(), pop_q.size() ? pop_q[0].pc : 32'h0); end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL flush_rvalid_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] flush_rvalid: %0d pops", pop_q.size());
   endtask

   task automatic test_random();
      bit fl; logic [31:0] tgt;
      clear_obs(); lat_min = 1; lat_max = 4;
      for (int i = 0; i < 600; i++) begin
         fl  = ($urandom_range(99) < 3) || (i == 100) || (i == 101);
         tgt = (i == 100 || i == 101) ? 32'hFFFF_FFF8 + 32'(i - 100) : $urandom;
         cycle($urandom_range(9) < 7, $urandom_range(9) < 6, fl, tgt);
      end
      drain();
      tests++; if (max_outst > MAXO || req_at_max != 0) begin fails++; $display("FAIL random_outstanding: max=%0d req_at_max=%0d required <=%0d/0", max_outst, req_at_max, MAXO); end
      foreach (grant_q[i]) begin tests++; if (grant_q[i].act !== grant_q[i].exp) begin fails++; $display("FAIL random_grant[%0d]: im_addr=%h required %h", i, grant_q[i].act, grant_q[i].exp); end end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL random_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] random: %0d grants %0d pops", grant_q.size(), pop_q.size());
   endtask

   task automatic test_reset_mid();
      lat_min = 3; lat_max = 3;
      repeat (5) cycle(0, 1, 0, 0);
      reset = 1'b0; #1;
      tests++; if (im_req !== 1'b0 || f_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_outputs: im_req=%b f_valid=%b required 0/0", im_req, f_valid); end
      tests++; if (im_addr !== RPC || f_pc !== RPC || f_instr !== 32'h0) begin fails++; $display("FAIL reset_mid_regs: im_addr=%h f_pc=%h f_instr=%h required %h/%h/0", im_addr, f_pc, f_instr, RPC, RPC); end
`ifdef IFB_PERF_CNT_EN
      tests++; if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin fails++; $display("FAIL reset_mid_perf: stall=%0d drop=%0d required 0/0", perf_stall_cnt, perf_drop_cnt); end
`endif
      do_reset(); clear_obs(); lat_min = 1; lat_max = 2;
      repeat (15) cycle(1, 1, 0, 0);
      drain();
      tests++; if (grant_q.size() == 0 || grant_q[0].act !== RPC) begin fails++; $display("FAIL reset_mid_restart: grants=%0d first addr=%h required %h", grant_q.size(), grant_q.size() ? grant_q[0].act : 32'hX, RPC); end
      foreach (pop_q[i]) begin tests++; if (pop_q[i].pc !== pop_q[i].exp_pc || pop_q[i].instr !== pop_q[i].exp_instr) begin fails++; $display("FAIL reset_mid_pop[%0d]: pc=%h instr=%h required %h/%h", i, pop_q[i].pc, pop_q[i].instr, pop_q[i].exp_pc, pop_q[i].exp_instr); end end
      $display("[TB] reset_mid: %0d pops after restart", pop_q.size());
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_latency();
      test_flush();
      test_flush_rvalid();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
